// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the byte producers, the arbiter and the FIFO.
// master = arbiter side, slave = requester/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int NREQ = 3,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] din;
    logic [NREQ-1:0]    gnt;
    logic               wr_fifo;
    logic [DW-1:0]      to_fifo_data;

    modport master (
        input  req,
        input  din,
        output gnt,
        output wr_fifo,
        output to_fifo_data
    );

    modport slave (
        output req,
        output din,
        input  gnt,
        input  wr_fifo,
        input  to_fifo_data
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter for the 4-deep byte FIFO.
// Credit counter stands in for the missing FIFO full flag.
module fifo_wr_arbiter #(
    parameter int NREQ  = 3,
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic              clk_50,
    input  logic              reset_n,
    fifo_wr_arbiter_if.master bus,
    input  logic              rd_toggle,
    output logic [2:0]        credits,
    output logic              credit_err,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_GAP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   r_winner;
    logic [PW-1:0]   w_win_idx;
    logic [PW-1:0]   w_idx;
    logic [PW:0]     w_sum;
    logic            w_found;
    logic            w_capture;
    logic            w_ret;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_sync3;
    logic [DW-1:0]   r_data;
    logic [2:0]      r_credits;
    logic            r_credit_err;
    logic            w_wr;
    logic [NREQ-1:0] w_gnt;

    // Two-flop synchroniser for the reader toggle, third flop for edge detect
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= rd_toggle;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_ret = r_sync2 ^ r_sync3;

    // Search from rr_ptr upward with wrap; lowest offset that is requesting wins
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        w_sum     = '0;
        w_idx     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (PW + 1)'(k);
            if (w_sum >= (PW + 1)'(NREQ)) begin
                w_sum = w_sum - (PW + 1)'(NREQ);
            end
            w_idx = w_sum[PW-1:0];
            if (bus.req[w_idx]) begin
                w_found   = 1'b1;
                w_win_idx = w_idx;
            end
        end
    end

    assign w_capture = (r_state == ST_IDLE) && w_found && (r_credits != 3'd0);

    // FSM state register
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and strobes; a write is always followed by a GAP cycle
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_gnt       = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_state_nxt     = ST_GAP;
                w_wr            = 1'b1;
                w_gnt[r_winner] = 1'b1;
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture winner, its byte and advance the round-robin pointer
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
            r_winner <= '0;
            r_data   <= '0;
        end else if (w_capture) begin
            r_winner <= w_win_idx;
            r_data   <= bus.din[w_win_idx*DW +: DW];
            r_rr_ptr <= (w_win_idx == PW'(NREQ - 1)) ? '0 : w_win_idx + 1'b1;
        end
    end

    // Credit count: capture spends one, return gives one back, both cancel
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_credits    <= 3'(DEPTH);
            r_credit_err <= 1'b0;
        end else begin
            case ({w_capture, w_ret})
                2'b10: r_credits <= r_credits - 3'd1;
                2'b01: begin
                    if (r_credits == 3'(DEPTH)) begin
                        r_credit_err <= 1'b1;
                    end else begin
                        r_credits <= r_credits + 3'd1;
                    end
                end
                default: r_credits <= r_credits;
            endcase
        end
    end

    assign bus.wr_fifo      = w_wr;
    assign bus.gnt          = w_gnt;
    assign bus.to_fifo_data = r_data;
    assign credits          = r_credits;
    assign credit_err       = r_credit_err;
    assign busy             = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: scoreboard of expected writes,
// directed credit and reset scenarios.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 3;
    localparam int DEPTH = 4;
    localparam int DW    = 8;

    logic       clk_50  = 1'b0;
    logic       reset_n = 1'b1;
    logic       tog_m   = 1'b0;
    logic       tog_a   = 1'b0;
    logic       rd_auto = 1'b0;
    logic       rd_toggle;
    logic [2:0] credits;
    logic       credit_err;
    logic       busy;

    assign rd_toggle = tog_m ^ tog_a;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    fifo_wr_arbiter #(
        .NREQ  (NREQ),
        .DEPTH (DEPTH),
        .DW    (DW)
    ) dut (
        .clk_50     (clk_50),
        .reset_n    (reset_n),
        .bus        (bus.master),
        .rd_toggle  (rd_toggle),
        .credits    (credits),
        .credit_err (credit_err),
        .busy       (busy)
    );

    always #10 clk_50 = ~clk_50;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic [DW-1:0]   data;
    } wr_t;

    wr_t        sb[$];
    wr_t        mon_e;
    int         n_wr = 0;
    int         n_extra = 0;
    int         cyc = 0;
    int         wr_cyc[$];
    logic [2:0] wr_cred[$];
    logic       prev_wr = 1'b0;
    int         rd_issued = 0;

    // Monitor: pops one expected write per wr_fifo strobe
    always @(negedge clk_50) begin
        cyc++;
        if (reset_n) begin
            if (prev_wr) chk("wr_gap", bus.wr_fifo, 0);
            if (!bus.wr_fifo && bus.gnt != '0) chk("gnt_nowr", bus.gnt, 0);
            chk("busy", busy, bus.wr_fifo | prev_wr);
            if (bus.wr_fifo) begin
                n_wr++;
                wr_cyc.push_back(cyc);
                wr_cred.push_back(credits);
                if (sb.size() == 0) begin
                    n_extra++;
                    chk("sb_extra", n_extra, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("wr_gnt", bus.gnt, mon_e.gnt);
                    chk("wr_data", bus.to_fifo_data, mon_e.data);
                end
            end
            prev_wr = bus.wr_fifo;
        end else begin
            prev_wr = 1'b0;
        end
    end

    // Reader model: one toggle per observed write when enabled
    always @(posedge clk_50) begin
        #1;
        if (!reset_n || !rd_auto) begin
            rd_issued = n_wr;
            if (!reset_n) tog_a = 1'b0;
        end else if (rd_issued < n_wr) begin
            tog_a = ~tog_a;
            rd_issued++;
        end
    end

    task automatic do_reset();
        chk("sb_empty", sb.size(), 0);
        sb.delete();
        reset_n = 1'b0;
        bus.req = '0;
        tog_m   = 1'b0;
        rd_auto = 1'b0;
        repeat (3) @(posedge clk_50);
        #1 reset_n = 1'b1;
    endtask

    task automatic wait_wr(input int target, input int limit, input string tag);
        int k;
        k = 0;
        while (n_wr < target && k < limit) begin
            @(posedge clk_50);
            #1;
            k++;
        end
        chk(tag, n_wr >= target, 1);
    endtask

    int base;
    int bi;
    int nb;
    int k;

    initial begin
        bus.req = '0;
        bus.din = '0;
        #1 reset_n = 1'b0;
        #4;
        chk("rst_wr", bus.wr_fifo, 0);
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cred", credits, DEPTH);
        chk("rst_err", credit_err, 0);
        chk("rst_data", bus.to_fifo_data, 0);
        repeat (2) @(posedge clk_50);
        #1 reset_n = 1'b1;

        // single byte from requester 1
        rd_auto = 1'b1;
        base = n_wr;
        nb = 0;
        bus.din[1*DW +: DW] = 8'hA5;
        sb.push_back(wr_t'{3'b010, 8'hA5});
        bus.req[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_50);
            if (busy) nb++;
            if (bus.gnt[1]) begin
                chk("sb_cred", credits, 3);
                @(posedge clk_50);
                #1 bus.req[1] = 1'b0;
            end
        end
        chk("sb_busy", nb, 2);
        chk("sb_cnt", n_wr - base, 1);
        chk("sb_ret", credits, 4);

        // round robin, all three requesting
        do_reset();
        rd_auto = 1'b1;
        bus.din = {8'h30, 8'h20, 8'h10};
        for (int i = 0; i < 6; i++) begin
            sb.push_back(wr_t'{3'(1 << (i % 3)), 8'(8'h10 * ((i % 3) + 1))});
        end
        base = n_wr;
        bi = wr_cyc.size();
        bus.req = 3'b111;
        wait_wr(base + 6, 60, "rr_done");
        bus.req = '0;
        for (int i = 1; i < 6; i++) begin
            chk("rr_gap", wr_cyc[bi+i] - wr_cyc[bi+i-1], 3);
        end
        for (int i = 0; i < 6; i++) begin
            chk("rr_cred", wr_cred[bi+i] != 3'd0, 1);
        end
        repeat (10) @(posedge clk_50);

        // credit exhaustion, no reads
        do_reset();
        bus.din[0 +: DW] = 8'h5C;
        for (int i = 0; i < 4; i++) sb.push_back(wr_t'{3'b001, 8'h5C});
        base = n_wr;
        bus.req[0] = 1'b1;
        wait_wr(base + 4, 40, "ex_four");
        repeat (50) @(posedge clk_50);
        #1;
        chk("ex_cnt", n_wr - base, 4);
        chk("ex_cred", credits, 0);
        chk("ex_busy", busy, 0);

        // one credit returned: one more write
        base = n_wr;
        sb.push_back(wr_t'{3'b001, 8'h5C});
        tog_m = ~tog_m;
        k = 0;
        do begin
            @(negedge clk_50);
            k++;
        end while (credits != 3'd1 && k < 10);
        chk("ret_edge", k - 1, 3);
        repeat (10) @(posedge clk_50);
        #1;
        chk("ret_cnt", n_wr - base, 1);
        chk("ret_cred", credits, 0);

        // second return lands on the capture edge of the first
        base = n_wr;
        sb.push_back(wr_t'{3'b001, 8'h5C});
        sb.push_back(wr_t'{3'b001, 8'h5C});
        @(posedge clk_50);
        #1 tog_m = ~tog_m;
        @(posedge clk_50);
        #1 tog_m = ~tog_m;
        k = 0;
        do begin
            @(negedge clk_50);
            k++;
        end while (credits != 3'd1 && k < 10);
        chk("sim_seen", credits, 1);
        @(negedge clk_50);
        chk("sim_wr", bus.wr_fifo, 1);
        chk("sim_cred", credits, 1);
        repeat (12) @(posedge clk_50);
        #1;
        chk("sim_cnt", n_wr - base, 2);
        chk("sim_end", credits, 0);
        bus.req = '0;

        // return with all credits present
        do_reset();
        @(posedge clk_50);
        #1 tog_m = ~tog_m;
        repeat (8) @(posedge clk_50);
        #1;
        chk("ovf_cred", credits, 4);
        chk("ovf_err", credit_err, 1);
        repeat (20) @(posedge clk_50);
        #1;
        chk("ovf_hold", credit_err, 1);
        do_reset();
        chk("ovf_clr", credit_err, 0);

        // reset while in WRITE
        bus.din = {8'h33, 8'h22, 8'h11};
        sb.push_back(wr_t'{3'b001, 8'h11});
        bus.req = 3'b101;
        k = 0;
        do begin
            @(negedge clk_50);
            k++;
        end while (!bus.wr_fifo && k < 20);
        chk("mw_seen", bus.wr_fifo, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mw_wr", bus.wr_fifo, 0);
        chk("mw_gnt", bus.gnt, 0);
        chk("mw_busy", busy, 0);
        repeat (2) @(posedge clk_50);
        #1 reset_n = 1'b1;
        chk("mw_cred", credits, 4);
        base = n_wr;
        sb.push_back(wr_t'{3'b001, 8'h11});
        wait_wr(base + 1, 20, "mw_next");
        bus.req = '0;

        repeat (5) @(posedge clk_50);
        chk("sb_final", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
